note_div_calc: RTL and testbench

Multi-cycle replacement for the combinational `1_0000_0000 / freq` dividers in the top level.
- Sits between music_example (raw freqL/freqR, 32 b) and note_gen (note_div_left/right, 22 b).
- Applies the octave shift, then computes both clock dividers with one shared serial restoring divider.
- Updates both outputs atomically, and only when an input has changed.

---
 rtl/note_div_pkg.sv | 66 ++++++
 rtl/note_div_calc_serial_divider.sv | 52 +++++
 rtl/note_div_calc.sv | 123 ++++++++++++
 tb/tb_note_div_calc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/note_div_pkg.sv
// Shared constants, state encoding and helpers for the note divider calculator.
// Defining NOTE_DIV_ROUND_EN switches the divider to round-to-nearest (one extra iteration per channel).
package note_div_pkg;

  localparam int DIVIDEND   = 100_000_000;
  localparam int DVD_W      = 27;
  localparam int OUT_W      = 22;
  localparam int SILENT_DIV = 1;

  // An octave-up shift of a 32-bit frequency needs 33 bits; the remainder needs one more.
  localparam int DS_W  = 33;
  localparam int REM_W = DS_W + 1;

`ifdef NOTE_DIV_ROUND_EN
  localparam int ITER = DVD_W + 1;
`else
  localparam int ITER = DVD_W;
`endif
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [2:0] OCT_DOWN = 3'd1;
  localparam logic [2:0] OCT_UP   = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    DIV_L,
    LOAD_R,
    DIV_R,
    COMMIT
  } state_t;

  function automatic logic [DS_W-1:0] effective_divisor(input logic [31:0] freq,
                                                       input logic [2:0]  octave);
    logic [DS_W-1:0] d;
    case (octave)
      OCT_DOWN: d = {2'b00, freq[31:1]};
      OCT_UP:   d = {freq, 1'b0};
      default:  d = {1'b0, freq};
    endcase
    return d;
  endfunction

  function automatic logic [ITER-1:0] dividend_for(input logic [DS_W-1:0] divisor);
`ifdef NOTE_DIV_ROUND_EN
    return ITER'(DIVIDEND) + ITER'(divisor >> 1);
`else
    return ITER'(DIVIDEND) + ITER'(divisor & '0);
`endif
  endfunction

  // A zero divisor means silence; otherwise keep the quotient inside what note_gen can count.
  function automatic logic [OUT_W-1:0] clamp_result(input logic [DS_W-1:0] divisor,
                                                    input logic [ITER-1:0] quotient);
    logic [OUT_W-1:0] r;
    if (divisor == '0)
      r = OUT_W'(SILENT_DIV);
    else if (quotient == '0)
      r = OUT_W'(1);
    else if (quotient > ITER'((1 << OUT_W) - 1))
      r = '1;
    else
      r = quotient[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/note_div_calc_serial_divider.sv
// Restoring divider producing one quotient bit per clock, MSB first.
// The dividend shifts out of the same register the quotient shifts into.
module serial_divider #(
  parameter int DVD_BITS = 27,
  parameter int DSR_BITS = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DVD_BITS-1:0] dividend,
  input  logic [DSR_BITS-1:0] divisor,
  output logic [DVD_BITS-1:0] quotient,
  output logic [DSR_BITS:0]   rem,
  output logic                valid
);

  localparam int CW = $clog2(DVD_BITS + 1);

  logic [DSR_BITS-1:0] dsr;
  logic [CW-1:0]       cnt;
  logic [DSR_BITS:0]   rem_shift;
  logic [DSR_BITS:0]   rem_diff;
  logic                fits;

  // The partial remainder always stays below the divisor, so its top bit is never needed in the shift.
  always_comb begin
    rem_shift = {rem[DSR_BITS-1:0], quotient[DVD_BITS-1]};
    rem_diff  = rem_shift - {1'b0, dsr};
    fits      = (rem_shift >= {1'b0, dsr});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      dsr      <= '0;
      cnt      <= '0;
    end else if (load) begin
      rem      <= '0;
      quotient <= dividend;
      dsr      <= divisor;
      cnt      <= CW'(DVD_BITS);
    end else if (cnt != '0) begin
      rem      <= fits ? rem_diff : rem_shift;
      quotient <= {quotient[DVD_BITS-2:0], fits};
      cnt      <= cnt - 1'b1;
    end
  end

  assign valid = (cnt == '0);

endmodule

// File: rtl/note_div_calc.sv
// Computes both note_gen clock dividers from raw frequencies with one shared serial divider.
// Optional round-to-nearest build: define NOTE_DIV_ROUND_EN.
module note_div_calc
  import note_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      freq_l,
  input  logic [31:0]      freq_r,
  input  logic [2:0]       octave,
  output logic [OUT_W-1:0] note_div_l,
  output logic [OUT_W-1:0] note_div_r,
  output logic             busy,
  output logic             done
);

  state_t state, state_next;

  logic [31:0]      snap_l, snap_r;
  logic [2:0]       snap_oct;
  logic             force_pass;
  logic [CNT_W-1:0] iter;
  logic [OUT_W-1:0] hold_l;

  logic             changed;
  logic             start;
  logic             div_load;
  logic [DS_W-1:0]  live_dsr_l;
  logic [DS_W-1:0]  snap_dsr_l;
  logic [DS_W-1:0]  snap_dsr_r;
  logic [DS_W-1:0]  div_dsr;
  logic [ITER-1:0]  quotient;
  logic [REM_W-1:0] rem;
  logic             valid;
  logic             unused_div;

  assign changed    = ({freq_l, freq_r, octave} != {snap_l, snap_r, snap_oct});
  assign start      = force_pass || changed;
  assign live_dsr_l = effective_divisor(freq_l, octave);
  assign snap_dsr_l = effective_divisor(snap_l, snap_oct);
  assign snap_dsr_r = effective_divisor(snap_r, snap_oct);
  assign unused_div = ^{rem, valid};

  serial_divider #(
    .DVD_BITS (ITER),
    .DSR_BITS (DS_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (dividend_for(div_dsr)),
    .divisor  (div_dsr),
    .quotient (quotient),
    .rem      (rem),
    .valid    (valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV_L;
      DIV_L:   if (iter == '0) state_next = LOAD_R;
      LOAD_R:  state_next = DIV_R;
      DIV_R:   if (iter == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The left channel loads straight from the live inputs on the same edge the snapshot is taken.
  always_comb begin
    busy     = (state != IDLE);
    div_load = 1'b0;
    div_dsr  = live_dsr_l;
    case (state)
      IDLE:   div_load = start;
      LOAD_R: begin
        div_load = 1'b1;
        div_dsr  = snap_dsr_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_l     <= '0;
      snap_r     <= '0;
      snap_oct   <= '0;
      force_pass <= 1'b1;
      iter       <= '0;
      hold_l     <= OUT_W'(SILENT_DIV);
      note_div_l <= OUT_W'(SILENT_DIV);
      note_div_r <= OUT_W'(SILENT_DIV);
      done       <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      if (div_load)
        iter <= CNT_W'(ITER - 1);
      else if (iter != '0)
        iter <= iter - 1'b1;
      if (state == IDLE && start) begin
        snap_l     <= freq_l;
        snap_r     <= freq_r;
        snap_oct   <= octave;
        force_pass <= 1'b0;
      end
      // Left result is complete once the right channel takes over the divider.
      if (state == LOAD_R)
        hold_l <= clamp_result(snap_dsr_l, quotient);
      if (state == COMMIT) begin
        note_div_l <= hold_l;
        note_div_r <= clamp_result(snap_dsr_r, quotient);
      end
    end
  end

endmodule

// File: tb/tb_note_div_calc.sv
// Directed bench for note_div_calc (default truncating build, 56-cycle latency).
module tb_note_div_calc;

  localparam int LAT = 56;

  typedef struct {
    logic [31:0] fl;
    logic [31:0] fr;
    logic [2:0]  oct;
    logic [21:0] el;
    logic [21:0] er;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] freq_l;
  logic [31:0] freq_r;
  logic [2:0]  octave;
  logic [21:0] note_div_l;
  logic [21:0] note_div_r;
  logic        busy;
  logic        done;

  int checks;
  int passes;

  note_div_calc dut (
    .clk        (clk),
    .rst        (rst),
    .freq_l     (freq_l),
    .freq_r     (freq_r),
    .octave     (octave),
    .note_div_l (note_div_l),
    .note_div_r (note_div_r),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] fl, input logic [31:0] fr,
                               input logic [2:0] oct);
    @(posedge clk);
    #1;
    freq_l = fl;
    freq_r = fr;
    octave = oct;
  endtask

  // Counts edges after the sampling edge until done is seen; -1 means it never came.
  task automatic waitDone(input int already, output int lat);
    lat = -1;
    for (int n = already + 1; n <= already + 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    int   bad;

    vecs[0] = '{32'd262,        32'd262,        3'd3, 22'd190839,  22'd190839};
    vecs[1] = '{32'd262,        32'd262,        3'd1, 22'd763358,  22'd763358};
    vecs[2] = '{32'd0,          32'd20,         3'd2, 22'd1,       22'd4194303};
    vecs[3] = '{32'd440,        32'd262,        3'd2, 22'd227272,  22'd381679};
    vecs[4] = '{32'd262,        32'd440,        3'd3, 22'd190839,  22'd113636};
    vecs[5] = '{32'd1,          32'd1,          3'd1, 22'd1,       22'd1};
    vecs[6] = '{32'hFFFF_FFFF,  32'h8000_0000,  3'd3, 22'd1,       22'd1};

    checks = 0;
    passes = 0;
    rst    = 1'b1;
    freq_l = 32'd262;
    freq_r = 32'd262;
    octave = 3'd2;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_div_l", 32'(note_div_l), 32'd1);
    checkOutput("reset_div_r", 32'(note_div_r), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);

    // Forced pass right after reset release.
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("forced_busy", 32'(busy), 32'd1);
    waitDone(0, lat);
    checkOutput("forced_latency", 32'(lat), 32'(LAT));
    checkOutput("forced_div_l", 32'(note_div_l), 32'd381679);
    checkOutput("forced_div_r", 32'(note_div_r), 32'd381679);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 32'(done), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].fl, vecs[i].fr, vecs[i].oct);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      waitDone(0, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      checkOutput($sformatf("vec%0d_div_l", i), 32'(note_div_l), 32'(vecs[i].el));
      checkOutput($sformatf("vec%0d_div_r", i), 32'(note_div_r), 32'(vecs[i].er));
    end

    // Right frequency changes ten cycles into a pass.
    applyStimulus(32'd262, 32'd262, 3'd2);
    @(posedge clk);
    #1;
    checkOutput("midchg_busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    freq_r = 32'd440;
    checkOutput("midchg_hold_l", 32'(note_div_l), 32'd1);
    waitDone(10, lat);
    checkOutput("midchg_latency", 32'(lat), 32'(LAT));
    checkOutput("midchg_div_l", 32'(note_div_l), 32'd381679);
    checkOutput("midchg_div_r", 32'(note_div_r), 32'd381679);
    @(posedge clk);
    #1;
    checkOutput("repass_busy", 32'(busy), 32'd1);
    waitDone(0, lat);
    checkOutput("repass_latency", 32'(lat), 32'(LAT));
    checkOutput("repass_div_l", 32'(note_div_l), 32'd381679);
    checkOutput("repass_div_r", 32'(note_div_r), 32'd227272);

    // Stable inputs must not start a pass.
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (busy || done) bad++;
    end
    checkOutput("stable_activity", 32'(bad), 32'd0);
    checkOutput("stable_div_l", 32'(note_div_l), 32'd381679);
    checkOutput("stable_div_r", 32'(note_div_r), 32'd227272);

    // Reset in the middle of a pass, then a forced pass.
    applyStimulus(32'd440, 32'd440, 3'd2);
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    repeat (29) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_div_l", 32'(note_div_l), 32'd1);
    checkOutput("abort_div_r", 32'(note_div_r), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("recover_busy", 32'(busy), 32'd1);
    waitDone(0, lat);
    checkOutput("recover_latency", 32'(lat), 32'(LAT));
    checkOutput("recover_div_l", 32'(note_div_l), 32'd227272);
    checkOutput("recover_div_r", 32'(note_div_r), 32'd227272);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
